multi_port_reg_file: RTL and testbench

MULTI_PORT_REG_FILE -- requirements
Module: multi_port_reg_file

---
 rtl/multi_port_reg_file.sv | 95 +++++++++
 tb/tb_multi_port_reg_file.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_reg_file.sv
// Register file with byte-enabled write port, N combinational read ports with optional
// write forwarding, a per-register pending-write scoreboard and write bookkeeping.
module multi_port_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic                       busy_set,
    input  logic [ADDR_W-1:0]          busy_addr,
    output logic                       zero_wr_err,
    input  logic                       err_clr,
    output logic [15:0]                wr_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              busy [DEPTH];
    logic [DATA_W-1:0] wr_merged;
    logic              wr_accept;
    logic              zero_wr;

    assign wr_accept = wr_en && (wr_addr != '0) && (wr_be != '0);
    assign zero_wr   = wr_en && (wr_addr == '0);

    genvar gi;

    // Register 0 resets to zero and can never be written, so it reads zero everywhere.
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs[gi] <= DATA_W'(gi);
            end else if (wr_accept && (wr_addr == ADDR_W'(gi))) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[b]) regs[gi][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end

        // A new producer issued in the same cycle as the write wins over the clear.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy[gi] <= 1'b0;
            end else if (busy_set && (busy_addr != '0) && (busy_addr == ADDR_W'(gi))) begin
                busy[gi] <= 1'b1;
            end else if (wr_accept && (wr_addr == ADDR_W'(gi))) begin
                busy[gi] <= 1'b0;
            end
        end
    end

    for (gi = 0; gi < NB; gi++) begin : g_merge
        assign wr_merged[8*gi +: 8] = wr_be[gi] ? wr_data[8*gi +: 8] : regs[wr_addr][8*gi +: 8];
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;
        logic              set_here;

        assign addr     = rd_addr[gi*ADDR_W +: ADDR_W];
        assign hit      = (BYPASS != 0) && wr_accept && (wr_addr == addr);
        assign set_here = busy_set && (busy_addr == addr);
        assign rd_data[gi*DATA_W +: DATA_W] = hit ? wr_merged : regs[addr];
        assign rd_busy[gi] = busy[addr] && !(hit && !set_here);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_wr_err <= 1'b0;
        end else if (zero_wr) begin
            zero_wr_err <= 1'b1;
        end else if (err_clr) begin
            zero_wr_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= 16'd0;
        end else if (wr_accept && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_multi_port_reg_file.sv
// Bench for multi_port_reg_file: behavioural model checked every negedge plus
// hand-computed literal expectations for the directed scenarios.
module tb_multi_port_reg_file;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int BP = 1;
    localparam int NB = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NR*AW-1:0]  rd_addr = '0;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [NB-1:0]     wr_be = '0;
    logic              busy_set = 1'b0;
    logic [AW-1:0]     busy_addr = '0;
    logic              zero_wr_err;
    logic              err_clr = 1'b0;
    logic [15:0]       wr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_port_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(BP)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .busy_set(busy_set), .busy_addr(busy_addr), .zero_wr_err(zero_wr_err),
        .err_clr(err_clr), .wr_count(wr_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model: architectural state, updated from the rules of each edge.
    logic [DW-1:0] m_reg [32];
    logic          m_busy [32];
    logic          m_err;
    int            m_cnt;
    logic          acc;
    assign acc = wr_en && (wr_addr != 0) && (wr_be != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  <= DW'(i);
                m_busy[i] <= 1'b0;
            end
            m_err <= 1'b0;
            m_cnt <= 0;
        end else begin
            if (acc) begin
                for (int b = 0; b < NB; b++)
                    if (wr_be[b]) m_reg[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                m_busy[wr_addr] <= 1'b0;
                if (m_cnt < 65535) m_cnt <= m_cnt + 1;
            end
            if (busy_set && busy_addr != 0) m_busy[busy_addr] <= 1'b1;
            if (wr_en && wr_addr == 0) m_err <= 1'b1;
            else if (err_clr) m_err <= 1'b0;
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = (a == 0) ? '0 : m_reg[a];
        if (BP != 0 && acc && wr_addr == a)
            for (int b = 0; b < NB; b++)
                if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic cleared_now;
        cleared_now = (BP != 0) && acc && (wr_addr == a) && !(busy_set && busy_addr == a);
        return (a != 0) && m_busy[a] && !cleared_now;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("model_rd_data%0d", k), 64'(rd_data[k*DW +: DW]),
                64'(exp_rd(rd_addr[k*AW +: AW])));
            chk($sformatf("model_rd_busy%0d", k), 64'(rd_busy[k]),
                64'(exp_busy(rd_addr[k*AW +: AW])));
        end
        chk("model_zero_wr_err", 64'(zero_wr_err), 64'(m_err));
        chk("model_wr_count", 64'(wr_count), 64'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_be = '0; busy_set = 1'b0; err_clr = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(); tick();
        set_rd(5, 31);
        #1;
        chk("rst_rd0", 64'(rd_data[31:0]), 64'h5);
        chk("rst_rd1", 64'(rd_data[63:32]), 64'h1F);
        chk("rst_busy", 64'(rd_busy), 64'h0);
        chk("rst_cnt", 64'(wr_count), 64'h0);
        rst_n = 1'b1;
        tick();
        chk("rel_rd0", 64'(rd_data[31:0]), 64'h5);
        chk("rel_rd1", 64'(rd_data[63:32]), 64'h1F);

        // Byte-merged forwarding on write
        set_rd(3, 31);
        wr_en = 1; wr_addr = 3; wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
        #1 chk("byp_pre", 64'(rd_data[31:0]), 64'h00BB00DD);
        tick(); idle(); #1;
        chk("byp_post", 64'(rd_data[31:0]), 64'h00BB00DD);
        chk("cnt_1", 64'(wr_count), 64'h1);
        set_rd(3, 3);
        wr_en = 1; wr_addr = 3; wr_data = 32'h11223344; wr_be = 4'b1010;
        #1 chk("byp_merge2", 64'(rd_data[63:32]), 64'h11BB33DD);
        tick(); idle(); #1;
        chk("same_port0", 64'(rd_data[31:0]), 64'h11BB33DD);
        chk("same_port1", 64'(rd_data[63:32]), 64'h11BB33DD);

        // Register 0 writes and the sticky error flag
        set_rd(0, 0);
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        #1 chk("r0_zero", 64'(rd_data), 64'h0);
        tick(); idle(); #1;
        chk("zerr_set", 64'(zero_wr_err), 64'h1);
        chk("zerr_cnt", 64'(wr_count), 64'h2);
        wr_en = 1; wr_addr = 0; wr_be = 4'h0; err_clr = 1;
        tick(); idle(); #1;
        chk("zerr_hold", 64'(zero_wr_err), 64'h1);
        err_clr = 1;
        tick(); idle(); #1;
        chk("zerr_clr", 64'(zero_wr_err), 64'h0);
        set_rd(4, 4);
        wr_en = 1; wr_addr = 4; wr_data = 32'hDEADBEEF; wr_be = 4'h0;
        tick(); idle(); #1;
        chk("be0_ignored", 64'(rd_data[31:0]), 64'h4);
        chk("be0_cnt", 64'(wr_count), 64'h2);

        // Scoreboard
        set_rd(0, 7);
        busy_set = 1; busy_addr = 7;
        #1 chk("busy_setcyc", 64'(rd_busy[1]), 64'h0);
        tick(); idle(); #1;
        chk("busy_after_set", 64'(rd_busy[1]), 64'h1);
        wr_en = 1; wr_addr = 7; wr_data = 32'h77; wr_be = 4'hF;
        #1 chk("busy_wrcyc", 64'(rd_busy[1]), 64'h0);
        tick(); idle(); #1;
        chk("busy_after_wr", 64'(rd_busy[1]), 64'h0);
        busy_set = 1; busy_addr = 7;
        tick(); idle();
        busy_set = 1; busy_addr = 7; wr_en = 1; wr_addr = 7; wr_data = 32'h78; wr_be = 4'hF;
        #1 chk("busy_both_cyc", 64'(rd_busy[1]), 64'h1);
        tick(); idle(); #1;
        chk("busy_both_after", 64'(rd_busy[1]), 64'h1);
        chk("cnt_4", 64'(wr_count), 64'h4);
        set_rd(0, 0);
        busy_set = 1; busy_addr = 0;
        tick(); idle(); #1;
        chk("busy_r0", 64'(rd_busy), 64'h0);
        busy_set = 1; busy_addr = 9;
        tick(); idle();

        // Saturation: 65530 writes bring the count from 4 to 16'hFFFE
        wr_en = 1; wr_addr = 1; wr_be = 4'hF;
        for (int i = 0; i < 65530; i++) begin
            wr_data = DW'(i);
            tick();
        end
        idle(); #1;
        chk("cnt_fffe", 64'(wr_count), 64'hFFFE);
        wr_en = 1; wr_addr = 1; wr_be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            wr_data = 32'hC0DE0000 + DW'(i);
            tick();
        end
        idle(); #1;
        chk("cnt_sat", 64'(wr_count), 64'hFFFF);
        set_rd(1, 9);
        #1;
        chk("r1_last", 64'(rd_data[31:0]), 64'hC0DE0002);
        chk("r9_busy", 64'(rd_busy[1]), 64'h1);

        // Reset mid-write
        set_rd(9, 9);
        wr_en = 1; wr_addr = 9; wr_data = 32'h12345678; wr_be = 4'hF;
        #2 rst_n = 1'b0; wr_en = 0;
        #1;
        chk("midrst_r9", 64'(rd_data[31:0]), 64'h9);
        chk("midrst_busy", 64'(rd_busy), 64'h0);
        chk("midrst_cnt", 64'(wr_count), 64'h0);
        tick();
        chk("rst_hold_r9", 64'(rd_data[63:32]), 64'h9);
        rst_n = 1'b1;
        wr_en = 1; wr_addr = 9; wr_data = 32'h12345678; wr_be = 4'hF;
        tick(); idle(); #1;
        chk("postrst_wr", 64'(rd_data[31:0]), 64'h12345678);
        chk("postrst_cnt", 64'(wr_count), 64'h1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
